// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the microRISC datapath: fetch, decode, execute, memory, writeback.
// It owns the shared memory port. A request that goes unanswered past TIMEOUT cycles traps in ERROR.
module multicycle_sequencer #(
    parameter int TIMEOUT   = 16,
    parameter int TIMEOUT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       reg_write,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic       mem_to_reg,
    input  logic       branch,
    input  logic       branch_ne,
    input  logic       jump,
    input  logic       jump_reg,
    input  logic       link,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       ab_we,
    output logic       alu_out_we,
    output logic       mdr_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       instr_done,
    output logic       bus_error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        ERROR     = 3'd7
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t               cur;
    state_t               nxt;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 wait_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= FETCH;
            wait_cnt <= '0;
        end else begin
            cur <= nxt;
            if (nxt != cur || mem_ready)
                wait_cnt <= '0;
            else if (mem_req)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The expiry test is evaluated only while a request is open. A ready in the same cycle takes precedence.
    assign wait_expired = (wait_cnt == WAIT_LAST);
    assign state        = rst ? 3'd0 : cur;

    always_comb begin
        nxt        = cur;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        ab_we      = 1'b0;
        alu_out_we = 1'b0;
        mdr_we     = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'b00;
        rf_we      = 1'b0;
        wb_sel     = 2'b00;
        instr_done = 1'b0;
        bus_error  = 1'b0;
        if (!rst) begin
            unique case (cur)
                FETCH: begin
                    if (enable) begin
                        mem_req = 1'b1;
                        if (mem_ready) begin
                            ir_we = 1'b1;
                            pc_we = 1'b1;
                            nxt   = DECODE;
                        end else if (wait_expired) begin
                            nxt = ERROR;
                        end
                    end
                end
                DECODE: begin
                    ab_we = 1'b1;
                    nxt   = EXECUTE;
                end
                EXECUTE: begin
                    alu_out_we = 1'b1;
                    if (jump_reg) begin
                        pc_we      = 1'b1;
                        pc_sel     = 2'b11;
                        instr_done = 1'b1;
                        nxt        = FETCH;
                    end else if (jump) begin
                        // PC already holds PC+1 from fetch, which is the link value.
                        pc_we      = 1'b1;
                        pc_sel     = 2'b10;
                        rf_we      = link;
                        wb_sel     = link ? 2'b10 : 2'b00;
                        instr_done = 1'b1;
                        nxt        = FETCH;
                    end else if (branch) begin
                        pc_we      = alu_zero ^ branch_ne;
                        pc_sel     = (alu_zero ^ branch_ne) ? 2'b01 : 2'b00;
                        instr_done = 1'b1;
                        nxt        = FETCH;
                    end else if (mem_read || mem_write) begin
                        nxt = MEM;
                    end else if (reg_write) begin
                        nxt = WRITEBACK;
                    end else begin
                        instr_done = 1'b1;
                        nxt        = FETCH;
                    end
                end
                MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = mem_write;
                    if (mem_ready) begin
                        if (mem_read) begin
                            mdr_we = 1'b1;
                            nxt    = WRITEBACK;
                        end else begin
                            instr_done = 1'b1;
                            nxt        = FETCH;
                        end
                    end else if (wait_expired) begin
                        nxt = ERROR;
                    end
                end
                WRITEBACK: begin
                    rf_we      = 1'b1;
                    wb_sel     = mem_to_reg ? 2'b01 : 2'b00;
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end
                ERROR: begin
                    bus_error = 1'b1;
                end
                default: nxt = FETCH;
            endcase
        end
    end

endmodule
